vproc_vreg_wr_arbiter: RTL and testbench



---
 rtl/vproc_vreg_wr_arbiter_pkg.sv | 13 +
 rtl/vproc_rr_picker.sv | 66 ++++++
 rtl/vproc_vreg_wr_arbiter.sv | 83 ++++++++
 tb/tb_vproc_vreg_wr_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vproc_vreg_wr_arbiter_pkg.sv
// Shared constants and helpers for the vector register file write arbiter.
// The arbiter row address is the vreg index followed by the row within that vreg.
package vproc_vreg_wr_arbiter_pkg;

    localparam int unsigned VREG_IDX_W = 5;
    localparam int unsigned VREG_N     = 32;

    // Index width that stays legal when only one item exists.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vproc_rr_picker.sv
// Combinational round-robin scan granting up to PORTS_WR requesters per cycle,
// skipping any requester whose row address is already granted this cycle.
module vproc_rr_picker
    import vproc_vreg_wr_arbiter_pkg::*;
#(
    parameter int unsigned REQ_N    = 4,
    parameter int unsigned PORTS_WR = 2,
    parameter int unsigned ADDR_W   = 7,
    localparam int unsigned IDX_W   = idx_width(REQ_N)
) (
    input  logic [IDX_W-1:0]    rr_ptr_i,
    input  logic                hold_i,
    input  logic [REQ_N-1:0]    req_valid_i,
    input  logic [ADDR_W-1:0]   req_addr_i [REQ_N],
    output logic [REQ_N-1:0]    grant_o,
    output logic [PORTS_WR-1:0] port_vld_o,
    output logic [IDX_W-1:0]    port_idx_o [PORTS_WR],
    output logic                any_grant_o,
    output logic [IDX_W-1:0]    rr_ptr_nxt_o
);

    logic [IDX_W-1:0]  r;
    logic [IDX_W-1:0]  last_idx;
    logic              conflict;
    int                n_grant;
    logic [ADDR_W-1:0] gaddr [PORTS_WR];

    always_comb begin
        // NOTE: every variable gets a default before the scan so no path leaves
        // it unassigned; a missing default here would infer a latch.
        grant_o    = '0;
        port_vld_o = '0;
        last_idx   = '0;
        r          = '0;
        conflict   = 1'b0;
        n_grant    = 0;
        for (int p = 0; p < int'(PORTS_WR); p++) begin
            port_idx_o[p] = '0;
            gaddr[p]      = '0;
        end

        for (int i = 0; i < int'(REQ_N); i++) begin
            r        = IDX_W'((int'(rr_ptr_i) + i) % int'(REQ_N));
            conflict = 1'b0;
            for (int p = 0; p < int'(PORTS_WR); p++) begin
                if (port_vld_o[p] && (gaddr[p] == req_addr_i[r])) conflict = 1'b1;
            end
            if (req_valid_i[r] && !hold_i && (n_grant < int'(PORTS_WR)) && !conflict) begin
                grant_o[r] = 1'b1;
                last_idx   = r;
                for (int p = 0; p < int'(PORTS_WR); p++) begin
                    if (p == n_grant) begin
                        port_vld_o[p] = 1'b1;
                        port_idx_o[p] = r;
                        gaddr[p]      = req_addr_i[r];
                    end
                end
                n_grant++;
            end
        end
    end

    assign any_grant_o  = |grant_o;
    assign rr_ptr_nxt_o = (last_idx == IDX_W'(REQ_N - 1)) ? '0 : last_idx + 1'b1;

endmodule

// File: rtl/vproc_vreg_wr_arbiter.sv
// Shares the register file write ports among REQ_N result producers; grants are
// combinational, register file writes come from flops one cycle after acceptance.
module vproc_vreg_wr_arbiter
    import vproc_vreg_wr_arbiter_pkg::*;
#(
    parameter int unsigned REQ_N    = 4,
    parameter int unsigned PORTS_WR = 2,
    parameter int unsigned VREG_W   = 128,
    parameter int unsigned PORT_W   = 32,
    localparam int unsigned ADDR_W  = VREG_IDX_W + $clog2(VREG_W / PORT_W)
) (
    input  logic                clk_i,
    input  logic                sync_rst_i,
    input  logic                hold_i,
    input  logic [REQ_N-1:0]    req_valid_i,
    output logic [REQ_N-1:0]    req_ready_o,
    input  logic [ADDR_W-1:0]   req_addr_i [REQ_N],
    input  logic [PORT_W-1:0]   req_data_i [REQ_N],
    input  logic [PORT_W/8-1:0] req_be_i   [REQ_N],
    output logic [ADDR_W-1:0]   wr_addr_o  [PORTS_WR],
    output logic [PORT_W-1:0]   wr_data_o  [PORTS_WR],
    output logic [PORT_W/8-1:0] wr_be_o    [PORTS_WR],
    output logic [PORTS_WR-1:0] wr_we_o,
    output logic [VREG_N-1:0]   pend_vreg_o
);

    localparam int unsigned IDX_W = idx_width(REQ_N);

    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    rr_ptr_nxt;
    logic [IDX_W-1:0]    port_idx [PORTS_WR];
    logic [PORTS_WR-1:0] port_vld;
    logic                any_grant;

    // Reset masks grants so nothing is accepted while the output stage is cleared.
    vproc_rr_picker #(
        .REQ_N    (REQ_N),
        .PORTS_WR (PORTS_WR),
        .ADDR_W   (ADDR_W)
    ) u_picker (
        .rr_ptr_i     (rr_ptr),
        .hold_i       (hold_i | sync_rst_i),
        .req_valid_i  (req_valid_i),
        .req_addr_i   (req_addr_i),
        .grant_o      (req_ready_o),
        .port_vld_o   (port_vld),
        .port_idx_o   (port_idx),
        .any_grant_o  (any_grant),
        .rr_ptr_nxt_o (rr_ptr_nxt)
    );

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            rr_ptr  <= '0;
            wr_we_o <= '0;
            for (int p = 0; p < int'(PORTS_WR); p++) begin
                wr_addr_o[p] <= '0;
                wr_data_o[p] <= '0;
                wr_be_o[p]   <= '0;
            end
        end else begin
            if (any_grant) rr_ptr <= rr_ptr_nxt;
            wr_we_o <= port_vld;
            for (int p = 0; p < int'(PORTS_WR); p++) begin
                if (port_vld[p]) begin
                    wr_addr_o[p] <= req_addr_i[port_idx[p]];
                    wr_data_o[p] <= req_data_i[port_idx[p]];
                    wr_be_o[p]   <= req_be_i[port_idx[p]];
                end
            end
        end
    end

    always_comb begin
        pend_vreg_o = '0;
        for (int p = 0; p < int'(PORTS_WR); p++) begin
            if (wr_we_o[p]) pend_vreg_o[wr_addr_o[p][ADDR_W-1 -: VREG_IDX_W]] = 1'b1;
        end
    end

endmodule

// File: tb/tb_vproc_vreg_wr_arbiter.sv
// Directed and random stimulus for the write arbiter, scored against a
// reference arbitration model and a register file image.
module tb_vproc_vreg_wr_arbiter;

    localparam int REQ_N    = 4;
    localparam int PORTS_WR = 2;
    localparam int VREG_W   = 128;
    localparam int PORT_W   = 32;
    localparam int ADDR_W   = 7;
    localparam int BE_W     = 4;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [PORT_W-1:0] data;
        logic [BE_W-1:0]   be;
    } wr_t;

    logic                clk_i = 1'b0;
    logic                sync_rst_i;
    logic                hold_i;
    logic [REQ_N-1:0]    req_valid_i;
    logic [REQ_N-1:0]    req_ready_o;
    logic [ADDR_W-1:0]   req_addr_i [REQ_N];
    logic [PORT_W-1:0]   req_data_i [REQ_N];
    logic [BE_W-1:0]     req_be_i   [REQ_N];
    logic [ADDR_W-1:0]   wr_addr_o  [PORTS_WR];
    logic [PORT_W-1:0]   wr_data_o  [PORTS_WR];
    logic [BE_W-1:0]     wr_be_o    [PORTS_WR];
    logic [PORTS_WR-1:0] wr_we_o;
    logic [31:0]         pend_vreg_o;

    vproc_vreg_wr_arbiter #(
        .REQ_N    (REQ_N),
        .PORTS_WR (PORTS_WR),
        .VREG_W   (VREG_W),
        .PORT_W   (PORT_W)
    ) dut (
        .clk_i       (clk_i),
        .sync_rst_i  (sync_rst_i),
        .hold_i      (hold_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .req_be_i    (req_be_i),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o),
        .wr_be_o     (wr_be_o),
        .wr_we_o     (wr_we_o),
        .pend_vreg_o (pend_vreg_o)
    );

    always #5 clk_i = ~clk_i;

    wr_t [PORTS_WR-1:0] exp_q [$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          mdl_rr   = 0;
    logic [3:0]  dut_grant = '0;
    int          wt [REQ_N];
    bit          starve_chk = 1'b0;
    logic [31:0] exp_rf [128];
    logic [31:0] dut_rf [128];
    logic [ADDR_W-1:0] pool [6];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] apply_be(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] be);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) if (be[b]) res[b*8 +: 8] = d[b*8 +: 8];
        return res;
    endfunction

    // One clock: predict grants, compare ready mid-cycle, compare write ports after the edge.
    task automatic cycle();
        wr_t [PORTS_WR-1:0] e;
        logic [ADDR_W-1:0]  ua [PORTS_WR];
        logic [3:0]         exp_grant;
        logic [31:0]        exp_pend;
        int                 n, last, r;
        bit                 dup, rst_now;
        @(negedge clk_i);
        rst_now   = sync_rst_i;
        exp_grant = '0;
        e         = '0;
        n         = 0;
        last      = 0;
        if (!sync_rst_i && !hold_i) begin
            for (int k = 0; k < REQ_N; k++) begin
                r   = (mdl_rr + k) % REQ_N;
                dup = 1'b0;
                for (int j = 0; j < n; j++) if (ua[j] == req_addr_i[r]) dup = 1'b1;
                if (req_valid_i[r] && n < PORTS_WR && !dup) begin
                    exp_grant[r] = 1'b1;
                    e[n] = '{we: 1'b1, addr: req_addr_i[r], data: req_data_i[r], be: req_be_i[r]};
                    ua[n] = req_addr_i[r];
                    last  = r;
                    n++;
                end
            end
        end
        dut_grant = req_ready_o;
        check("ready", 64'(req_ready_o), 64'(exp_grant));
        exp_q.push_back(e);

        @(posedge clk_i);
        #1;
        if (rst_now) mdl_rr = 0;
        else if (n > 0) mdl_rr = (last + 1) % REQ_N;

        e = exp_q.pop_front();
        check("wr_we", 64'(wr_we_o), 64'({e[1].we, e[0].we}));
        exp_pend = '0;
        for (int p = 0; p < PORTS_WR; p++) begin
            if (e[p].we || rst_now) begin
                check("wr_addr", 64'(wr_addr_o[p]), 64'(e[p].addr));
                check("wr_data", 64'(wr_data_o[p]), 64'(e[p].data));
                check("wr_be",   64'(wr_be_o[p]),   64'(e[p].be));
            end
            if (e[p].we) begin
                exp_pend[e[p].addr[ADDR_W-1 -: 5]] = 1'b1;
                exp_rf[e[p].addr] = apply_be(exp_rf[e[p].addr], e[p].data, e[p].be);
            end
            if (wr_we_o[p] === 1'b1)
                dut_rf[wr_addr_o[p]] = apply_be(dut_rf[wr_addr_o[p]], wr_data_o[p], wr_be_o[p]);
        end
        check("pend_vreg", 64'(pend_vreg_o), 64'(exp_pend));
        if (wr_we_o === 2'b11) check("same_row", 64'(wr_addr_o[0] != wr_addr_o[1]), 64'(1));

        if (starve_chk) begin
            for (int q = 0; q < REQ_N; q++) begin
                if (dut_grant[q]) begin
                    check("starve", 64'(wt[q] <= 1), 64'(1));
                    wt[q] = 0;
                end else if (req_valid_i[q]) begin
                    wt[q]++;
                end
            end
        end
    endtask

    task automatic retire();
        for (int r = 0; r < REQ_N; r++) if (dut_grant[r]) req_valid_i[r] = 1'b0;
    endtask

    task automatic all_valid(input logic [31:0] tag);
        for (int r = 0; r < REQ_N; r++) begin
            req_valid_i[r] = 1'b1;
            req_addr_i[r]  = ADDR_W'(r * 8);
            req_data_i[r]  = tag + 32'(r);
            req_be_i[r]    = 4'hF;
        end
    endtask

    task automatic refill(input int pct, input bit distinct);
        for (int r = 0; r < REQ_N; r++) begin
            if (dut_grant[r] || !req_valid_i[r]) begin
                if ($urandom_range(0, 99) < pct) begin
                    req_valid_i[r] = 1'b1;
                    req_addr_i[r]  = distinct ? {5'($urandom_range(0, 31)), 2'(r)}
                                              : pool[$urandom_range(0, 5)];
                    req_data_i[r]  = $urandom;
                    req_be_i[r]    = 4'($urandom);
                end else begin
                    req_valid_i[r] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        pool = '{7'h15, 7'h16, 7'h40, 7'h41, 7'h7f, 7'h00};
        for (int a = 0; a < 128; a++) begin
            exp_rf[a] = '0;
            dut_rf[a] = '0;
        end
        for (int r = 0; r < REQ_N; r++) begin
            wt[r]         = 0;
            req_addr_i[r] = '0;
            req_data_i[r] = '0;
            req_be_i[r]   = '0;
        end
        sync_rst_i  = 1'b1;
        hold_i      = 1'b0;
        req_valid_i = '0;
        repeat (2) cycle();
        sync_rst_i = 1'b0;

        // All valid, distinct rows: two grants per cycle in scan order.
        all_valid(32'hA000);
        cycle();
        check("t1_grant0", 64'(dut_grant), 64'(4'b0011));
        retire();
        cycle();
        check("t1_grant1", 64'(dut_grant), 64'(4'b1100));
        check("t1_we", 64'(wr_we_o), 64'(2'b11));
        retire();
        cycle();

        // Same-row requests serialize in scan order.
        req_valid_i   = 4'b1101;
        req_addr_i[0] = 7'h15; req_data_i[0] = 32'h1111_0000; req_be_i[0] = 4'hF;
        req_addr_i[2] = 7'h15; req_data_i[2] = 32'h2222_0000; req_be_i[2] = 4'h3;
        req_addr_i[3] = 7'h40; req_data_i[3] = 32'h3333_0000; req_be_i[3] = 4'h0;
        cycle();
        check("t2_grant0", 64'(dut_grant), 64'(4'b1001));
        retire();
        cycle();
        check("t2_grant1", 64'(dut_grant), 64'(4'b0100));
        retire();
        cycle();

        // Hold suppresses grants and keeps the pointer.
        all_valid(32'hB000);
        hold_i = 1'b1;
        repeat (3) begin
            cycle();
            check("t3_hold_grant", 64'(dut_grant), 64'(0));
            check("t3_hold_we", 64'(wr_we_o), 64'(0));
        end
        hold_i = 1'b0;
        cycle();
        check("t3_resume", 64'(dut_grant), 64'(4'b1001));
        retire();
        cycle();
        check("t3_resume2", 64'(dut_grant), 64'(4'b0110));
        retire();
        cycle();

        // Single streaming requester on port 0.
        for (int i = 0; i < 10; i++) begin
            req_valid_i   = 4'b1000;
            req_addr_i[3] = 7'(32'h20 + i);
            req_data_i[3] = 32'(i);
            req_be_i[3]   = 4'hF;
            cycle();
            check("t4_grant", 64'(dut_grant), 64'(4'b1000));
            check("t4_we", 64'(wr_we_o), 64'(2'b01));
            check("t4_pend", 64'(pend_vreg_o), 64'(32'd1 << ((32'h20 + i) >> 2)));
        end
        req_valid_i = '0;
        cycle();

        // Reset with both ports busy drops the output stage and rewinds the pointer.
        all_valid(32'hC000);
        cycle();
        check("t5_we", 64'(wr_we_o), 64'(2'b11));
        sync_rst_i = 1'b1;
        cycle();
        check("t5_rst_we", 64'(wr_we_o), 64'(0));
        check("t5_rst_pend", 64'(pend_vreg_o), 64'(0));
        sync_rst_i = 1'b0;
        cycle();
        check("t5_first", 64'(dut_grant), 64'(4'b0011));
        retire();
        cycle();
        retire();
        cycle();

        // Random traffic with frequent row conflicts and occasional hold.
        for (int c = 0; c < 300; c++) begin
            hold_i = ($urandom_range(0, 9) == 0);
            refill(70, 1'b0);
            cycle();
        end
        hold_i = 1'b0;

        // Conflict-free traffic: starvation bound of two cycles.
        for (int r = 0; r < REQ_N; r++) wt[r] = 0;
        starve_chk = 1'b1;
        for (int c = 0; c < 200; c++) begin
            refill(80, 1'b1);
            cycle();
        end
        starve_chk  = 1'b0;
        req_valid_i = '0;
        repeat (2) cycle();

        for (int a = 0; a < 128; a++) check("regfile", 64'(dut_rf[a]), 64'(exp_rf[a]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
